// File: rtl/veerwolf_sw_debounce_if.sv
// Switch conditioner signal bundle: raw pins and firmware controls in, conditioned
// level, edge strobes, sticky change flags and interrupt out.
interface veerwolf_sw_debounce_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] i_sw;
  logic [WIDTH-1:0] i_chg_clr;
  logic [WIDTH-1:0] i_irq_en;
  logic [WIDTH-1:0] o_sw;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic [WIDTH-1:0] o_chg;
  logic             o_irq;

  modport master (
    output i_sw, i_chg_clr, i_irq_en,
    input  o_sw, o_rise, o_fall, o_chg, o_irq
  );

  modport slave (
    input  i_sw, i_chg_clr, i_irq_en,
    output o_sw, o_rise, o_fall, o_chg, o_irq
  );
endinterface

// File: rtl/veerwolf_sw_debounce.sv
// Two-flop synchroniser plus independent per-bit debouncer for the board switches,
// with registered edge strobes, sticky change flags and a maskable interrupt.
module veerwolf_sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic                    clk_core,
  input logic                    rst_core,
  veerwolf_sw_debounce_if.slave  sw_if
);
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] accept;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no latch is inferred.
    sw_d   = sw_q;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          accept[i] = 1'b1;
          sw_d[i]   = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d = accept & s2_q;
    fall_d = accept & ~s2_q;
    // A new accept outranks a same-cycle clear so no event is lost.
    chg_d  = (chg_q & ~sw_if.i_chg_clr) | accept;
  end

  always_ff @(posedge clk_core) begin
    // NOTE: sequential state uses non-blocking assignments only; the counter array is
    // small flops (not a RAM), so it is cleared by reset along with everything else.
    if (rst_core) begin
      s1_q   <= '0;
      s2_q   <= '0;
      sw_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= sw_if.i_sw;
      s2_q   <= s1_q;
      sw_q   <= sw_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_if.o_sw   = sw_q;
  assign sw_if.o_rise = rise_q;
  assign sw_if.o_fall = fall_q;
  assign sw_if.o_chg  = chg_q;
  assign sw_if.o_irq  = |(chg_q & sw_if.i_irq_en);
endmodule

// File: tb/tb_veerwolf_sw_debounce.sv
// Directed bench for veerwolf_sw_debounce (WIDTH=16, DEBOUNCE_CYCLES=4): expected strobe
// events are queued with their due edge; a negedge monitor pops and compares them.
module tb_veerwolf_sw_debounce;
  localparam int WIDTH   = 16;
  localparam int DB      = 4;
  localparam int LATENCY = DB + 2;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sw;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  evt_t exp_q[$];

  veerwolf_sw_debounce_if #(.WIDTH(WIDTH)) sw_if ();

  veerwolf_sw_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_core(clk),
    .rst_core(rst),
    .sw_if   (sw_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after driving a new pin level at a negedge: the next edge samples it.
  task automatic expect_evt(input logic [WIDTH-1:0] rise, input logic [WIDTH-1:0] fall,
                            input logic [WIDTH-1:0] sw);
    evt_t e;
    e.cyc  = cyc + LATENCY;
    e.rise = rise;
    e.fall = fall;
    e.sw   = sw;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (|sw_if.o_rise || |sw_if.o_fall) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", {sw_if.o_rise, sw_if.o_fall}, 32'h0);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        check("evt_edge", cyc, e.cyc);
        check("evt_rise", 32'(sw_if.o_rise), 32'(e.rise));
        check("evt_fall", 32'(sw_if.o_fall), 32'(e.fall));
        check("evt_sw",   32'(sw_if.o_sw),   32'(e.sw));
      end
    end
  end

  initial begin
    #50us;
    $display("FAIL watchdog: simulation exceeded time budget at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sw_if.i_sw      = 16'hFFFF;
    sw_if.i_chg_clr = '0;
    sw_if.i_irq_en  = 16'hFFFF;

    // 1: switches held high through reset produce a rise after release
    cycles(3);
    check("rst_sw",   32'(sw_if.o_sw),   32'h0);
    check("rst_chg",  32'(sw_if.o_chg),  32'h0);
    check("rst_rise", 32'(sw_if.o_rise), 32'h0);
    check("rst_irq",  32'(sw_if.o_irq),  32'h0);
    rst = 1'b0;
    expect_evt(16'hFFFF, 16'h0000, 16'hFFFF);
    cycles(LATENCY + 2);
    check("s1_sw",  32'(sw_if.o_sw),  32'hFFFF);
    check("s1_chg", 32'(sw_if.o_chg), 32'hFFFF);
    check("s1_irq", 32'(sw_if.o_irq), 32'h1);

    // 2: a 3-cycle glitch on bit 3 is rejected
    rst = 1'b1;
    sw_if.i_sw     = '0;
    sw_if.i_irq_en = '0;
    cycles(2);
    rst = 1'b0;
    cycles(2);
    check("s2_rst_sw", 32'(sw_if.o_sw), 32'h0);
    sw_if.i_sw[3] = 1'b1;
    cycles(3);
    sw_if.i_sw[3] = 1'b0;
    cycles(10);
    check("s2_sw",  32'(sw_if.o_sw),  32'h0);
    check("s2_chg", 32'(sw_if.o_chg), 32'h0);

    // 3: clean rise then fall on bit 3
    sw_if.i_sw[3] = 1'b1;
    expect_evt(16'h0008, 16'h0000, 16'h0008);
    cycles(LATENCY + 2);
    check("s3_sw_hi", 32'(sw_if.o_sw), 32'h0008);
    sw_if.i_sw[3] = 1'b0;
    expect_evt(16'h0000, 16'h0008, 16'h0000);
    cycles(LATENCY + 2);
    check("s3_sw_lo", 32'(sw_if.o_sw),  32'h0000);
    check("s3_chg",   32'(sw_if.o_chg), 32'h0008);
    sw_if.i_chg_clr = 16'hFFFF;
    cycles(1);
    sw_if.i_chg_clr = '0;
    check("s3_clr", 32'(sw_if.o_chg), 32'h0000);

    // 4: interrupt masking, clear, and set-wins-over-clear on bit 5
    sw_if.i_sw[5] = 1'b1;
    expect_evt(16'h0020, 16'h0000, 16'h0020);
    cycles(LATENCY + 2);
    check("s4_irq_off", 32'(sw_if.o_irq), 32'h0);
    sw_if.i_irq_en = 16'h0020;
    #1;
    check("s4_irq_on", 32'(sw_if.o_irq), 32'h1);
    check("s4_chg",    32'(sw_if.o_chg), 32'h0020);
    cycles(1);
    sw_if.i_chg_clr = 16'h0020;
    cycles(1);
    sw_if.i_chg_clr = '0;
    check("s4_clr_chg", 32'(sw_if.o_chg), 32'h0000);
    check("s4_clr_irq", 32'(sw_if.o_irq), 32'h0);
    sw_if.i_sw[5] = 1'b0;
    expect_evt(16'h0000, 16'h0020, 16'h0000);
    cycles(LATENCY - 1);
    sw_if.i_chg_clr = 16'h0020;
    cycles(1);
    sw_if.i_chg_clr = '0;
    check("s4_setwin_chg", 32'(sw_if.o_chg), 32'h0020);
    check("s4_setwin_irq", 32'(sw_if.o_irq), 32'h1);
    sw_if.i_irq_en  = '0;
    #1;
    check("s4_en_off_chg", 32'(sw_if.o_chg), 32'h0020);
    sw_if.i_chg_clr = 16'hFFFF;
    cycles(1);
    sw_if.i_chg_clr = '0;

    // 5: bits 0 and 15 together
    sw_if.i_sw = 16'h8001;
    expect_evt(16'h8001, 16'h0000, 16'h8001);
    cycles(LATENCY + 2);
    check("s5_chg", 32'(sw_if.o_chg), 32'h8001);
    sw_if.i_sw = 16'h0000;
    expect_evt(16'h0000, 16'h8001, 16'h0000);
    cycles(LATENCY + 2);
    check("s5_sw", 32'(sw_if.o_sw), 32'h0000);
    sw_if.i_chg_clr = 16'hFFFF;
    cycles(1);
    sw_if.i_chg_clr = '0;

    // 6: reset part-way through a run on bit 7 restarts the full latency
    sw_if.i_sw[7] = 1'b1;
    cycles(3);
    rst = 1'b1;
    cycles(2);
    check("s6_rst_sw",  32'(sw_if.o_sw),  32'h0);
    check("s6_rst_chg", 32'(sw_if.o_chg), 32'h0);
    rst = 1'b0;
    expect_evt(16'h0080, 16'h0000, 16'h0080);
    cycles(LATENCY + 2);
    check("s6_sw",  32'(sw_if.o_sw),  32'h0080);
    check("s6_chg", 32'(sw_if.o_chg), 32'h0080);

    check("pending_events", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
